multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath_pkg.sv | 55 +++++
 rtl/multicycle_datapath_alu.sv | 52 +++++
 rtl/multicycle_datapath_imm_ext.sv | 33 +++
 rtl/multicycle_datapath_mc_sequencer.sv | 88 ++++++++
 rtl/multicycle_datapath.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/multicycle_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath_pkg
// Description : Shared types and encodings for the multicycle datapath:
//               sequencer state enum, ResultSrc/ImmSrc/ALUControl codes and
//               width-dependent helper constants.
// Revision    : 1.0
// ============================================================================
package multicycle_datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // ResultSrc encodings
    localparam logic [1:0] c_RES_ALUOUT = 2'd0;
    localparam logic [1:0] c_RES_MDR    = 2'd1;
    localparam logic [1:0] c_RES_PC4    = 2'd2;
    localparam logic [1:0] c_RES_IMM    = 2'd3;

    // ImmSrc encodings
    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_J = 3'd3;
    localparam logic [2:0] c_IMM_U = 3'd4;

    // ALUControl encodings
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLT  = 4'd5;
    localparam logic [3:0] c_ALU_SLTU = 4'd6;
    localparam logic [3:0] c_ALU_SLL  = 4'd7;
    localparam logic [3:0] c_ALU_SRL  = 4'd8;
    localparam logic [3:0] c_ALU_SRA  = 4'd9;

    // Instruction word and register-field widths are fixed by the ISA
    localparam int c_INSTR_W      = 32;
    localparam int c_REG_FIELD_W  = 5;
    localparam int c_PC_STEP      = 4;

    // Shift-amount width for a given datapath width (5 for 32, 6 for 64)
    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Parameterised-width integer ALU with zero and signed
//               less-than flags.
// Revision    : 1.0
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_alu_control,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_comparison
);
    import multicycle_datapath_pkg::*;

    localparam int c_SHAMT_W = shamt_width(WIDTH);

    logic [c_SHAMT_W-1:0] w_shamt;
    logic                 w_lt;
    logic                 w_ltu;

    assign w_shamt = i_b[c_SHAMT_W-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);
    assign w_ltu   = i_a < i_b;

    // Operation select
    always_comb begin
        o_result = '0;
        case (i_alu_control)
            c_ALU_ADD:  o_result = i_a + i_b;
            c_ALU_SUB:  o_result = i_a - i_b;
            c_ALU_AND:  o_result = i_a & i_b;
            c_ALU_OR:   o_result = i_a | i_b;
            c_ALU_XOR:  o_result = i_a ^ i_b;
            c_ALU_SLT:  o_result = WIDTH'(w_lt);
            c_ALU_SLTU: o_result = WIDTH'(w_ltu);
            c_ALU_SLL:  o_result = i_a << w_shamt;
            c_ALU_SRL:  o_result = i_a >> w_shamt;
            c_ALU_SRA:  o_result = WIDTH'($signed(i_a) >>> w_shamt);
            default:    o_result = '0;
        endcase
    end

    assign o_zero       = (o_result == '0);
    assign o_comparison = w_lt;

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath_imm_ext.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext
// Description : Immediate extractor; sign-extends I/S/B/J/U immediates to
//               WIDTH bits.
// Revision    : 1.0
// ============================================================================
module imm_ext #(
    parameter int WIDTH = 32
) (
    input  logic [31:7]      i_instr,
    input  logic [2:0]       i_imm_src,
    output logic [WIDTH-1:0] o_imm
);
    import multicycle_datapath_pkg::*;

    // Format select with sign extension through signed size casts
    always_comb begin
        o_imm = '0;
        case (i_imm_src)
            c_IMM_I: o_imm = WIDTH'($signed(i_instr[31:20]));
            c_IMM_S: o_imm = WIDTH'($signed({i_instr[31:25], i_instr[11:7]}));
            c_IMM_B: o_imm = WIDTH'($signed({i_instr[31], i_instr[7],
                                              i_instr[30:25], i_instr[11:8], 1'b0}));
            c_IMM_J: o_imm = WIDTH'($signed({i_instr[31], i_instr[19:12],
                                              i_instr[20], i_instr[30:21], 1'b0}));
            c_IMM_U: o_imm = WIDTH'($signed({i_instr[31:12], 12'b0}));
            default: o_imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer and memory handshake for
//               the multicycle datapath. Produces register load enables.
// Revision    : 1.0
// ============================================================================
module mc_sequencer (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_ack,
    input  logic i_mem_read,
    input  logic i_mem_write,
    output logic o_mem_req,
    output logic o_mem_we,
    output logic o_addr_sel,
    output logic o_ir_we,
    output logic o_ab_we,
    output logic o_alu_we,
    output logic o_mdr_we,
    output logic o_wb
);
    import multicycle_datapath_pkg::*;

    state_t r_state;
    state_t w_next;
    logic   w_req;
    logic   w_we;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_we       = 1'b0;
        o_addr_sel = 1'b0;
        o_ir_we    = 1'b0;
        o_ab_we    = 1'b0;
        o_alu_we   = 1'b0;
        o_mdr_we   = 1'b0;
        o_wb       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (i_mem_ack) begin
                    o_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                o_ab_we = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                o_alu_we = 1'b1;
                w_next   = (i_mem_read || i_mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_req      = 1'b1;
                w_we       = i_mem_write;
                o_addr_sel = 1'b1;
                if (i_mem_ack) begin
                    o_mdr_we = 1'b1;
                    w_next   = S_WB;
                end
            end
            S_WB: begin
                o_wb   = rst;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Request drops combinationally the moment reset asserts
    assign o_mem_req = w_req & rst;
    assign o_mem_we  = w_we & rst;

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_datapath
// Description : Multicycle RISC-V style datapath with unified variable-
//               latency memory port, external decoder controls and a debug
//               register read port.
// Revision    : 1.0
// ============================================================================
module multicycle_datapath #(
    parameter int             XLEN     = 32,
    parameter int             NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              instr,
    input  logic                     PCSrc,
    input  logic                     JumpSrc,
    input  logic                     ALUSrc,
    input  logic                     RegWrite,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               ResultSrc,
    input  logic [2:0]               ImmSrc,
    input  logic [3:0]               ALUControl,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     mem_ack,
    output logic [XLEN-1:0]          PC,
    output logic                     zero,
    output logic                     comparison,
    output logic                     retire,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr,
    output logic [XLEN-1:0]          dbg_rdata
);
    import multicycle_datapath_pkg::*;

    localparam int              c_IDX_W = $clog2(NREGS);
    localparam logic [XLEN-1:0] c_FOUR  = XLEN'(c_PC_STEP);
    localparam logic [XLEN-1:0] c_ONE   = XLEN'(1);

    logic [XLEN-1:0]      r_pc;
    logic [31:0]          r_ir;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [XLEN-1:0]      r_immext;
    logic [XLEN-1:0]      r_aluout;
    logic [XLEN-1:0]      r_mdr;
    logic                 r_zero;
    logic                 r_cmp;
    logic [XLEN-1:0]      r_regs [NREGS];

    logic                 w_addr_sel;
    logic                 w_ir_we;
    logic                 w_ab_we;
    logic                 w_alu_we;
    logic                 w_mdr_we;
    logic                 w_wb;

    logic [c_REG_FIELD_W-1:0] w_rs1;
    logic [c_REG_FIELD_W-1:0] w_rs2;
    logic [c_REG_FIELD_W-1:0] w_rd;
    logic                     w_rs1_ok;
    logic                     w_rs2_ok;
    logic                     w_rd_ok;
    logic [c_IDX_W-1:0]       w_rs1_idx;
    logic [c_IDX_W-1:0]       w_rs2_idx;
    logic [c_IDX_W-1:0]       w_rd_idx;
    logic [XLEN-1:0]          w_rs1_val;
    logic [XLEN-1:0]          w_rs2_val;

    logic [XLEN-1:0]      w_imm;
    logic [XLEN-1:0]      w_alu_b;
    logic [XLEN-1:0]      w_alu_y;
    logic                 w_alu_zero;
    logic                 w_alu_cmp;
    logic [XLEN-1:0]      w_pc_plus4;
    logic [XLEN-1:0]      w_pc_next;
    logic [XLEN-1:0]      w_result;

    mc_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_mem_ack   (mem_ack),
        .i_mem_read  (MemRead),
        .i_mem_write (MemWrite),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_addr_sel  (w_addr_sel),
        .o_ir_we     (w_ir_we),
        .o_ab_we     (w_ab_we),
        .o_alu_we    (w_alu_we),
        .o_mdr_we    (w_mdr_we),
        .o_wb        (w_wb)
    );

    imm_ext #(.WIDTH(XLEN)) u_imm (
        .i_instr   (r_ir[31:7]),
        .i_imm_src (ImmSrc),
        .o_imm     (w_imm)
    );

    assign w_alu_b = ALUSrc ? r_immext : r_b;

    alu #(.WIDTH(XLEN)) u_alu (
        .i_a           (r_a),
        .i_b           (w_alu_b),
        .i_alu_control (ALUControl),
        .o_result      (w_alu_y),
        .o_zero        (w_alu_zero),
        .o_comparison  (w_alu_cmp)
    );

    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_rd  = r_ir[11:7];

    assign w_rs1_idx = w_rs1[c_IDX_W-1:0];
    assign w_rs2_idx = w_rs2[c_IDX_W-1:0];
    assign w_rd_idx  = w_rd[c_IDX_W-1:0];

    // Register indices beyond NREGS read as zero and never write
    if (c_IDX_W >= c_REG_FIELD_W) begin : g_full_index
        assign w_rs1_ok = 1'b1;
        assign w_rs2_ok = 1'b1;
        assign w_rd_ok  = 1'b1;
    end else begin : g_part_index
        assign w_rs1_ok = ~|w_rs1[c_REG_FIELD_W-1:c_IDX_W];
        assign w_rs2_ok = ~|w_rs2[c_REG_FIELD_W-1:c_IDX_W];
        assign w_rd_ok  = ~|w_rd[c_REG_FIELD_W-1:c_IDX_W];
    end

    assign w_rs1_val = w_rs1_ok ? r_regs[w_rs1_idx] : '0;
    assign w_rs2_val = w_rs2_ok ? r_regs[w_rs2_idx] : '0;

    assign w_pc_plus4 = r_pc + c_FOUR;

    // Writeback result select
    always_comb begin
        w_result = r_aluout;
        case (ResultSrc)
            c_RES_ALUOUT: w_result = r_aluout;
            c_RES_MDR:    w_result = r_mdr;
            c_RES_PC4:    w_result = w_pc_plus4;
            c_RES_IMM:    w_result = r_immext;
            default:      w_result = r_aluout;
        endcase
    end

    // Next PC: sequential, PC-relative branch/jal, or register-relative jalr
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (PCSrc) begin
            if (JumpSrc) begin
                w_pc_next = (r_a + r_immext) & ~c_ONE;
            end else begin
                w_pc_next = r_pc + r_immext;
            end
        end
    end

    // Datapath holding registers, each loaded in the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_immext <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_zero   <= 1'b0;
            r_cmp    <= 1'b0;
        end else begin
            if (w_ir_we) begin
                r_ir <= mem_rdata[c_INSTR_W-1:0];
            end
            if (w_ab_we) begin
                r_a      <= w_rs1_val;
                r_b      <= w_rs2_val;
                r_immext <= w_imm;
            end
            if (w_alu_we) begin
                r_aluout <= w_alu_y;
                r_zero   <= w_alu_zero;
                r_cmp    <= w_alu_cmp;
            end
            if (w_mdr_we) begin
                r_mdr <= mem_rdata;
            end
            if (w_wb) begin
                r_pc <= w_pc_next;
            end
        end
    end

    // Register file; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb && RegWrite && w_rd_ok && (w_rd_idx != '0)) begin
            r_regs[w_rd_idx] <= w_result;
        end
    end

    assign instr      = r_ir;
    assign PC         = r_pc;
    assign zero       = r_zero;
    assign comparison = r_cmp;
    assign retire     = w_wb;
    assign mem_addr   = w_addr_sel ? r_aluout : r_pc;
    assign mem_wdata  = r_b;
    assign dbg_rdata  = r_regs[dbg_raddr];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_datapath
// Description : Directed self-checking bench; acts as decoder and memory.
// Revision    : 1.0
// ============================================================================
module tb_multicycle_datapath;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        PCSrc, JumpSrc, ALUSrc, RegWrite, MemRead, MemWrite;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] PC;
    logic        zero, comparison, retire;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int          n_cmp = 0;
    int          n_err = 0;

    logic        st_seen = 1'b0;
    logic [31:0] st_addr = 32'hFFFF_FFFF;
    logic [31:0] st_data = 32'h0;

    always #5 clk = ~clk;

    multicycle_datapath #(.XLEN(XLEN), .NREGS(NREGS), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .PCSrc(PCSrc), .JumpSrc(JumpSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .PC(PC), .zero(zero), .comparison(comparison), .retire(retire),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input int idx, input logic [31:0] exp);
        dbg_raddr = 5'(idx);
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    // Runs one instruction as decoder + memory; returns once back in FETCH
    task automatic run(input string tag, input logic [31:0] ins,
                       input logic [1:0] rs, input logic [2:0] is, input logic [3:0] ac,
                       input logic asrc, input logic rw, input logic mr, input logic mw,
                       input logic pcs, input logic js, input int fwait, input int exp_cyc);
        int          cycles = -1;
        int          waitn  = 0;
        int          phase  = 0;
        logic        done   = 1'b0;
        logic        stable = 1'b1;
        logic [31:0] hold   = '0;
        @(negedge clk);
        ResultSrc = rs; ImmSrc = is; ALUControl = ac; ALUSrc = asrc;
        RegWrite = rw; MemRead = mr; MemWrite = mw; PCSrc = pcs; JumpSrc = js;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ack = 1'b0;
            if (retire) begin
                done   = 1'b1;
                cycles = c + 1;
            end else if (mem_req) begin
                if (waitn == 0) hold = mem_addr;
                else if (mem_addr !== hold) stable = 1'b0;
                if (waitn == ((phase == 0) ? fwait : 0)) begin
                    mem_ack = 1'b1;
                    if (phase == 0) begin
                        mem_rdata = ins;
                    end else if (mem_we) begin
                        st_seen = 1'b1;
                        st_addr = mem_addr;
                        st_data = mem_wdata;
                    end else begin
                        mem_rdata = (mem_addr == st_addr) ? st_data : 32'h0;
                    end
                    phase = 1;
                    waitn = 0;
                end else begin
                    waitn++;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk({tag, " cycles"}, 64'(cycles), 64'(exp_cyc));
        chk({tag, " addr stable"}, 64'(stable), 64'd1);
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0; dbg_raddr = '0;
        PCSrc = 0; JumpSrc = 0; ALUSrc = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        ResultSrc = '0; ImmSrc = '0; ALUControl = '0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_we", 64'(mem_we), 64'd0);
        chk("rst retire", 64'(retire), 64'd0);
        chk("rst PC", 64'(PC), 64'h0);
        rst = 1'b1;
        #1;
        chk("post-rst mem_req", 64'(mem_req), 64'd1);
        chk("post-rst mem_addr", 64'(mem_addr), 64'h0);
        for (int i = 0; i < NREGS; i++) rd("post-rst reg", i, 32'h0);

        // addi x1,x0,5 zero-wait
        run("addi x1", 32'h0050_0093, 2'd0, 3'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 4);
        rd("x1", 1, 32'h5);
        chk("PC after addi", 64'(PC), 64'h4);

        // lui x2,0xDEADC with a 3-cycle fetch wait
        run("lui x2 wait3", 32'hDEAD_C137, 2'd3, 3'd4, 4'd0, 0, 1, 0, 0, 0, 0, 3, 7);
        rd("x2 lui", 2, 32'hDEAD_C000);
        chk("PC after lui", 64'(PC), 64'h8);

        // beq x0,x0,+16 taken at PC=8
        run("beq", 32'h0000_0863, 2'd0, 3'd2, 4'd1, 0, 0, 0, 0, 1, 0, 0, 4);
        chk("PC after beq", 64'(PC), 64'd24);
        chk("beq zero", 64'(zero), 64'd1);
        chk("beq comparison", 64'(comparison), 64'd0);

        // addi x2,x2,-273 gives 0xDEADBEEF (negative immediate)
        run("addi x2", 32'hEEF1_0113, 2'd0, 3'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 4);
        rd("x2", 2, 32'hDEAD_BEEF);
        chk("PC after addi x2", 64'(PC), 64'd28);

        // addi x0,x0,7 must not change x0
        run("addi x0", 32'h0070_0013, 2'd0, 3'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0, 4);
        rd("x0", 0, 32'h0);

        // sw x2,0x100(x0)
        run("sw", 32'h1020_2023, 2'd0, 3'd1, 4'd0, 1, 0, 0, 1, 0, 0, 0, 5);
        chk("sw we seen", 64'(st_seen), 64'd1);
        chk("sw addr", 64'(st_addr), 64'h100);
        chk("sw wdata", 64'(st_data), 64'hDEAD_BEEF);

        // lw x3,0x100(x0)
        run("lw", 32'h1000_2183, 2'd1, 3'd0, 4'd0, 1, 1, 1, 0, 0, 0, 0, 5);
        rd("x3", 3, 32'hDEAD_BEEF);
        chk("PC after lw", 64'(PC), 64'd40);

        // Reset asserted while a load is waiting in MEM
        @(negedge clk);
        mem_rdata = 32'h1000_2183; mem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("MEM mem_req", 64'(mem_req), 64'd1);
        chk("MEM mem_addr", 64'(mem_addr), 64'h100);
        #1 rst = 1'b0;
        #1;
        chk("mid-MEM rst mem_req", 64'(mem_req), 64'd0);
        chk("mid-MEM rst PC", 64'(PC), 64'h0);
        @(negedge clk);
        rd("x2 after rst", 2, 32'h0);
        rst = 1'b1;
        #1;
        chk("refetch mem_req", 64'(mem_req), 64'd1);
        chk("refetch mem_addr", 64'(mem_addr), 64'h0);
        chk("refetch mem_we", 64'(mem_we), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
